// File: rtl/shift_right_seq.sv
// Iterative right-shift unit: SRL, SRA or ROR by one bit per clock, driven by
// the control FSM through a start/busy/done handshake.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  state_t             state;
  state_t             state_nx;
  logic [SHAMT_W-1:0] count;
  logic [1:0]         op_q;
  logic               accept;
  logic [WIDTH-1:0]   shifted;

  // A new operation may begin from IDLE or straight out of DONE.
  assign accept = start && (state != S_SHIFT);

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = (shamt == '0) ? S_DONE : S_SHIFT;
        else       state_nx = S_IDLE;
      end
      S_SHIFT: begin
        if (count == SHAMT_W'(1)) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    shifted = {1'b0, data_out[WIDTH-1:1]};
    case (op_q)
      OP_SRA:  shifted = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
      OP_ROR:  shifted = {data_out[0], data_out[WIDTH-1:1]};
      default: shifted = {1'b0, data_out[WIDTH-1:1]};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      data_out <= '0;
      count    <= '0;
      op_q     <= 2'b00;
    end else begin
      state <= state_nx;
      if (accept) begin
        data_out <= data_in;
        op_q     <= op;
        count    <= shamt;
      end else if (state == S_SHIFT) begin
        data_out <= shifted;
        count    <= count - SHAMT_W'(1);
      end
    end
  end

  // Handshake outputs decode the state register only.
  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
